// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, does one AXI-lite-style read per instruction, hands the word to decode.
// Optional build macro IFU_ALIGN_CHECK_EN flags misaligned next-PCs without a bus read.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_arvalid,
    input  logic        imem_arready,
    output logic [31:0] imem_araddr,
    input  logic        imem_rvalid,
    output logic        imem_rready,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  imem_rresp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [1:0]  out_fault,
    input  logic        pc_update_valid,
    input  logic [31:0] pc_next
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_WAIT
    } state_t;

    localparam logic [1:0] FAULT_NONE   = 2'b00;
    localparam logic [1:0] FAULT_ACCESS = 2'b01;
`ifdef IFU_ALIGN_CHECK_EN
    localparam logic [1:0] FAULT_ALIGN  = 2'b10;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] opc_q, opc_d;
    logic [1:0]  fault_q, fault_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        ovalid_q, ovalid_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        opc_d   = opc_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: state_d = S_ADDR;
            S_ADDR: begin
                if (imem_arready) state_d = S_DATA;
            end
            S_DATA: begin
                if (imem_rvalid) begin
                    opc_d = pc_q;
                    if (imem_rresp != 2'b00) begin
                        inst_d  = NOP_INST;
                        fault_d = FAULT_ACCESS;
                    end else begin
                        inst_d  = imem_rdata;
                        fault_d = FAULT_NONE;
                    end
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pc_update_valid) begin
                    pc_d    = pc_next;
                    fault_d = FAULT_NONE;
                    state_d = S_ADDR;
`ifdef IFU_ALIGN_CHECK_EN
                    // Misaligned target: present the fault directly, never touch the bus.
                    if (pc_next[1:0] != 2'b00) begin
                        inst_d  = NOP_INST;
                        opc_d   = pc_next;
                        fault_d = FAULT_ALIGN;
                        state_d = S_HOLD;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode, so they stay Moore.
    always_comb begin
        arvalid_d = (state_d == S_ADDR);
        rready_d  = (state_d == S_DATA);
        ovalid_d  = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            opc_q     <= RESET_PC;
            fault_q   <= FAULT_NONE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ovalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            opc_q     <= opc_d;
            fault_q   <= fault_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ovalid_q  <= ovalid_d;
        end
    end

    assign imem_arvalid = arvalid_q;
    assign imem_araddr  = pc_q;
    assign imem_rready  = rready_q;
    assign out_valid    = ovalid_q;
    assign out_inst     = inst_q;
    assign out_pc       = opc_q;
    assign out_fault    = fault_q;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: reset checks, table-driven fetch vectors with a memory responder and an expectation queue.
module tb_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_arvalid;
    logic        imem_arready;
    logic [31:0] imem_araddr;
    logic        imem_rvalid;
    logic        imem_rready;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_rresp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [1:0]  out_fault;
    logic        pc_update_valid;
    logic [31:0] pc_next;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  fault;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [31:0] pc_next;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ar_stall;
        int          r_stall;
        logic [31:0] exp_inst;
        logic [1:0]  exp_fault;
        int          exp_lat;
        int          exp_ar;
    } vec_t;

    vec_t vecs[6];

    ifu #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_arvalid   (imem_arvalid),
        .imem_arready   (imem_arready),
        .imem_araddr    (imem_araddr),
        .imem_rvalid    (imem_rvalid),
        .imem_rready    (imem_rready),
        .imem_rdata     (imem_rdata),
        .imem_rresp     (imem_rresp),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_fault      (out_fault),
        .pc_update_valid(pc_update_valid),
        .pc_next        (pc_next)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Serves the bus from the cycle after the triggering edge until out_valid appears.
    task automatic fetch(input logic [31:0] exp_addr, input int ar_stall, input int r_stall,
                         input logic [31:0] rdata, input logic [1:0] rresp, input logic stale,
                         input int exp_ar);
        int   cyc = 0;
        int   ar_seen = 0;
        int   r_seen = 0;
        int   first_ar = 0;
        bit   done = 0;
        bit   addr_bad = 0;
        bit   overlap = 0;
        exp_t e;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            pc_update_valid = 1'b0;
            if (out_valid) begin
                done = 1;
            end else begin
                if (imem_arvalid) begin
                    ar_seen++;
                    if (first_ar == 0) first_ar = cyc;
                    if (imem_araddr !== exp_addr) addr_bad = 1;
                    if (r_seen > 0) overlap = 1;
                end
                imem_arready = (ar_seen > ar_stall);
                if (imem_rready) begin
                    r_seen++;
                    imem_rvalid = (r_seen > r_stall);
                    imem_rdata  = rdata;
                    imem_rresp  = rresp;
                end else begin
                    imem_rvalid = stale;
                    imem_rdata  = 32'hBAD0_0000;
                    imem_rresp  = 2'b00;
                end
            end
        end
        imem_arready = 1'b0;
        imem_rvalid  = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL fetch_timeout: no out_valid within %0d cycles, expected latency %0d", cyc, 3 + ar_stall + r_stall);
        end else if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty: out_valid with pc %h, expected no output", out_pc);
        end else begin
            e = exp_q.pop_front();
            chk("out_inst", out_inst, e.inst);
            chk("out_pc", out_pc, e.pc);
            chk("out_fault", {30'd0, out_fault}, {30'd0, e.fault});
            chk("latency", cyc, e.lat);
            chk("arvalid_cycles", ar_seen, exp_ar);
            chk("araddr_stable", {31'd0, addr_bad}, 32'd0);
            chk("ar_during_data", {31'd0, overlap}, 32'd0);
            if (exp_ar > 0) chk("first_ar_cycle", first_ar, 1);
            chk("hold_no_bus", {30'd0, imem_arvalid, imem_rready}, 32'd0);
        end
    endtask

    // Starts in HOLD; stalls decode, optionally pokes a stray pc update, then accepts.
    task automatic accept(input int stall, input logic pulse_pcu);
        logic [31:0] s_inst = out_inst;
        logic [31:0] s_pc   = out_pc;
        logic [1:0]  s_flt  = out_fault;
        bit          unstable = 0;
        bit          stray_ar = 0;
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            pc_update_valid = 1'b0;
            if (!out_valid || out_inst !== s_inst || out_pc !== s_pc || out_fault !== s_flt) unstable = 1;
            if (pulse_pcu && i == 1) begin
                pc_update_valid = 1'b1;
                pc_next = 32'h8000_0004;
            end
        end
        chk("hold_stable", {31'd0, unstable}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("wait_out_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (imem_arvalid) stray_ar = 1;
            @(negedge clk);
        end
        chk("wait_no_fetch", {31'd0, stray_ar}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        imem_arready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'd0;
        imem_rresp = 2'b00;
        out_ready = 1'b0;
        pc_update_valid = 1'b0;
        pc_next = 32'd0;

        vecs[0] = '{32'h8000_0010, 32'h00a0_0113, 2'b00, 3, 0, 32'h00a0_0113, 2'b00, 6, 4};
        vecs[1] = '{32'h8000_0014, 32'hFFFF_FFFF, 2'b10, 0, 0, NOP_INST,      2'b01, 3, 1};
        vecs[2] = '{32'h8000_0018, 32'h0020_81b3, 2'b00, 0, 2, 32'h0020_81b3, 2'b00, 5, 1};
`ifdef IFU_ALIGN_CHECK_EN
        vecs[3] = '{32'h8000_0002, 32'h1234_5678, 2'b00, 0, 0, NOP_INST,      2'b10, 1, 0};
`else
        vecs[3] = '{32'h8000_0002, 32'h1234_5678, 2'b00, 0, 0, 32'h1234_5678, 2'b00, 3, 1};
`endif
        vecs[4] = '{32'h8000_001c, 32'hDEAD_BEEF, 2'b01, 1, 1, NOP_INST,      2'b01, 5, 2};
        vecs[5] = '{32'h0000_0100, 32'h0000_0073, 2'b00, 2, 3, 32'h0000_0073, 2'b00, 8, 3};

        #12;
        chk("rst_arvalid", {31'd0, imem_arvalid}, 32'd0);
        chk("rst_rready", {31'd0, imem_rready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_araddr", imem_araddr, RESET_PC);
        chk("rst_out_pc", out_pc, RESET_PC);
        chk("rst_out_inst", out_inst, NOP_INST);
        chk("rst_out_fault", {30'd0, out_fault}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{32'h0050_0093, RESET_PC, 2'b00, 3});
        fetch(RESET_PC, 0, 0, 32'h0050_0093, 2'b00, 1'b0, 1);
        accept(5, 1'b1);

        foreach (vecs[i]) begin
            pc_update_valid = 1'b1;
            pc_next = vecs[i].pc_next;
            exp_q.push_back('{vecs[i].exp_inst, vecs[i].pc_next, vecs[i].exp_fault, vecs[i].exp_lat});
            fetch(vecs[i].pc_next, vecs[i].ar_stall, vecs[i].r_stall, vecs[i].rdata,
                  vecs[i].rresp, 1'b0, vecs[i].exp_ar);
            accept(i % 3, 1'b0);
        end

        // Reset while a read is outstanding, then leave a stale rvalid up across the release.
        pc_update_valid = 1'b1;
        pc_next = 32'h8000_0020;
        @(negedge clk);
        pc_update_valid = 1'b0;
        imem_arready = 1'b1;
        @(negedge clk);
        imem_arready = 1'b0;
        chk("mid_rready", {31'd0, imem_rready}, 32'd1);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0000;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valids", {29'd0, imem_arvalid, imem_rready, out_valid}, 32'd0);
        chk("mid_rst_araddr", imem_araddr, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{32'h0010_0073, RESET_PC, 2'b00, 4});
        fetch(RESET_PC, 1, 0, 32'h0010_0073, 2'b00, 1'b1, 2);
        accept(1, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the multi-cycle RV32 core. It holds the architectural PC, issues one read per instruction on the AXI-lite-style instruction-memory read channel, and presents the fetched word to the decode stage through a valid/ready handshake. The decode stage slices `out_inst` into opcode/func3/func7/bit-21 for the control generator. The unit then waits for the commit stage to return the next PC before fetching again.

## Interface
- `RESET_PC`, default 32'h8000_0000, PC loaded on reset.
- `NOP_INST`, default 32'h0000_0013, word driven on `out_inst` at reset and on any fault.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_arvalid`  out  1  read-address valid.
- `imem_arready`  in  1  read-address ready.
- `imem_araddr`  out  32  fetch address, equals PC.
- `imem_rvalid`  in  1  read-data valid.
- `imem_rready`  out  1  read-data ready.
- `imem_rdata`  in  32  instruction word.
- `imem_rresp`  in  2  response; 2'b00 OKAY, anything else is an access fault.
- `out_valid`  out  1  instruction available to decode.
- `out_ready`  in  1  decode accepts instruction.
- `out_inst`  out  32  instruction word.
- `out_pc`  out  32  PC of `out_inst`.
- `out_fault`  out  2  2'b00 none, 2'b01 access fault, 2'b10 misaligned.
- `pc_update_valid`  in  1  commit stage supplies the next PC.
- `pc_next`  in  32  next PC.

## Operation
- States: IDLE, ADDR, DATA, HOLD, WAIT. Reset state is IDLE.
- IDLE: goes to ADDR unconditionally on the next edge.
- ADDR: `imem_arvalid`=1, with `imem_araddr`=PC held stable. On `imem_arready`, go to DATA.
- DATA: `imem_rready`=1. On `imem_rvalid`:
  - capture `imem_rdata` into `out_inst` and PC into `out_pc`;
  - `out_fault`=01 if `imem_rresp`≠00, and in that case `out_inst`=NOP_INST;
  - go to HOLD.
- HOLD: `out_valid`=1. On `out_ready`, go to WAIT.
- WAIT: on `pc_update_valid`, PC←`pc_next`, clear `out_fault`, go to ADDR.
- `pc_update_valid` outside WAIT is ignored; PC is unchanged.
- `imem_rvalid` outside DATA and `out_ready` outside HOLD are ignored.
- Handshake outputs are Moore (decoded from state only). Nothing combinationally depends on `*_ready` or `*_valid` inputs.
- `out_inst`, `out_pc` and `out_fault` are registered. They are stable from entry to HOLD until the next capture.

## Timing
- Reset values:
  - `imem_arvalid`=0, `imem_rready`=0, `out_valid`=0;
  - `imem_araddr`=`out_pc`=RESET_PC;
  - `out_inst`=NOP_INST, `out_fault`=00.
- Reset asserted mid-transaction forces IDLE immediately and drops all valids/readies. The pending bus response is abandoned.
- First `imem_arvalid` is high in the 2nd cycle after `rst_n` rises.
- Zero-wait memory (arready tied 1, rvalid one cycle after the address handshake): `out_valid` rises 3 cycles after the `pc_update_valid` edge.
- Each stalled cycle of `imem_arready`, `imem_rvalid` or `out_ready` adds exactly one cycle. There is no timeout.
- At most one outstanding read. `imem_arvalid` never rises while DATA is pending.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined:
  - In WAIT, if `pc_next[1:0]`≠00, PC←`pc_next` and the FSM goes straight to HOLD with no bus read.
  - It presents `out_fault`=10, `out_inst`=NOP_INST, `out_pc`=`pc_next`.
- Undefined:
  - No alignment check; `pc_next` is driven to `imem_araddr` unmodified.
  - `out_fault` never equals 10.

## Test plan
- Reset release with `imem_arready`=1 and rdata 32'h00500093 returned next cycle:
  - `imem_araddr`=8000_0000 in cycle 2;
  - `out_valid` in cycle 4 with `out_inst`=00500093, `out_pc`=8000_0000, fault 00.
- Hold `out_ready`=0 for 5 cycles: `out_valid` stays 1 and outputs stay stable. Pulse `pc_update_valid` with `pc_next`=8000_0004 during HOLD: it is ignored, and no new `imem_arvalid` follows.
- In WAIT, `pc_next`=8000_0010 with `imem_arready` low for 3 cycles: `imem_arvalid` held 4 cycles with address 8000_0010; `out_valid` follows the response.
- `imem_rresp`=2'b10 with rdata FFFF_FFFF: `out_inst`=0000_0013, `out_fault`=01.
- `IFU_ALIGN_CHECK_EN` with `pc_next`=8000_0002: no `imem_arvalid`; `out_valid` next cycle with fault 10 and `out_pc`=8000_0002. Without the macro, a read is issued at 8000_0002.
- Assert `rst_n` low in DATA: all valids drop in the same cycle. Stale `imem_rvalid` after release is ignored, and fetch restarts at RESET_PC.
